instr_load_sequencer: RTL and testbench

Controller in front of the instruction RAM. In LOAD mode it assembles 6-byte UART frames (opcode, sel, op1h, op1l, op2h, op2l) into RAM write fields and issues one load pulse per frame. In RUN mode it steps the RAM read address 0..count-1 and hands each fetched instruction to the execution datapath through a valid/done handshake. It sits between the UART receiver, the instruction RAM and the ALU/executor.

---
 rtl/instr_load_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_instr_load_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_load_sequencer.sv
// Instruction load/run sequencer: assembles UART frames into RAM write fields,
// then steps the RAM read address through a valid/done handshake with the executor.
// Optional build macro FRAME_CHECKSUM_EN adds a trailing XOR checksum byte per frame.
module instr_load_sequencer #(
  parameter int unsigned NUMBER_OF_INSTRUCTIONS = 4,
  parameter int unsigned TIMEOUT_CYCLES         = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        start,
  input  logic        exec_done,
  output logic [7:0]  opcode,
  output logic [7:0]  sel,
  output logic [7:0]  op1h,
  output logic [7:0]  op1l,
  output logic [7:0]  op2h,
  output logic [7:0]  op2l,
  output logic        load,
  output logic [11:0] addr,
  output logic        instr_valid,
  output logic [11:0] loaded_cnt,
  output logic        busy,
  output logic        prog_done,
  output logic        frame_err
);

`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = 7;
`else
  localparam int unsigned FRAME_BYTES = 6;
`endif
  localparam int unsigned FIELDS = 6;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_LOAD    = 3'd1,
    S_FETCH   = 3'd2,
    S_WAIT    = 3'd3,
    S_EXEC    = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [FIELDS-1:0][7:0]   fields_q, fields_d;
  logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [CNT_W-1:0]         loaded_cnt_q, loaded_cnt_d;
  logic [CNT_W-1:0]         addr_q, addr_d;
  logic                     load_q, load_d;
  logic                     instr_valid_q, instr_valid_d;
  logic                     busy_q, busy_d;
  logic                     prog_done_q, prog_done_d;
  logic                     frame_err_q, frame_err_d;

  logic run_req_c;
  logic rx_take_c;
  logic frame_last_c;
  logic frame_ok_c;
  logic exec_last_c;

  // A run request wins over a coincident byte; bytes are only accepted while loading.
  assign run_req_c    = start && (state_q == S_COLLECT) && (byte_idx_q == '0)
                        && (loaded_cnt_q != '0);
  assign rx_take_c    = rx_valid && !run_req_c
                        && ((state_q == S_COLLECT) || (state_q == S_LOAD));
  assign frame_last_c = rx_take_c && (byte_idx_q == IDX_W'(FRAME_BYTES - 1));
  assign exec_last_c  = (addr_q == (loaded_cnt_q - CNT_W'(1)));

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum_c;
  always_comb begin
    csum_c = '0;
    for (int i = 0; i < FIELDS; i++) csum_c = csum_c ^ fields_q[i];
  end
  assign frame_ok_c = (csum_c == rx_data);
`else
  assign frame_ok_c = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_COLLECT;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: begin
        if (run_req_c)         state_d = S_FETCH;
        else if (frame_last_c) state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_COLLECT;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_EXEC;
      S_EXEC: begin
        if (exec_done) state_d = exec_last_c ? S_COLLECT : S_FETCH;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    fields_d      = fields_q;
    byte_idx_d    = byte_idx_q;
    tmo_d         = tmo_q;
    loaded_cnt_d  = loaded_cnt_q;
    addr_d        = addr_q;
    load_d        = 1'b0;
    instr_valid_d = instr_valid_q;
    prog_done_d   = prog_done_q;
    frame_err_d   = frame_err_q;
    busy_d        = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_EXEC);

    if (rx_take_c) begin
      for (int i = 0; i < FIELDS; i++) begin
        if (byte_idx_q == IDX_W'(i)) fields_d[i] = rx_data;
      end
      byte_idx_d = frame_last_c ? '0 : byte_idx_q + IDX_W'(1);
      tmo_d      = '0;
    end else if ((state_q == S_COLLECT) && (byte_idx_q != '0) && (TIMEOUT_CYCLES != 0)) begin
      // Partial frame idle too long: drop it but keep the previous fields.
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_d       = '0;
        byte_idx_d  = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (frame_last_c) begin
      if (frame_ok_c && (loaded_cnt_q < CNT_W'(NUMBER_OF_INSTRUCTIONS))) begin
        load_d       = 1'b1;
        loaded_cnt_d = loaded_cnt_q + CNT_W'(1);
      end else begin
        frame_err_d = 1'b1;
      end
    end

    if (run_req_c) begin
      addr_d      = '0;
      prog_done_d = 1'b0;
    end

    if (state_q == S_WAIT) instr_valid_d = 1'b1;

    if ((state_q == S_EXEC) && exec_done) begin
      instr_valid_d = 1'b0;
      if (exec_last_c) prog_done_d = 1'b1;
      else             addr_d      = addr_q + CNT_W'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      fields_q      <= '0;
      byte_idx_q    <= '0;
      tmo_q         <= '0;
      loaded_cnt_q  <= '0;
      addr_q        <= '0;
      load_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      prog_done_q   <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      fields_q      <= fields_d;
      byte_idx_q    <= byte_idx_d;
      tmo_q         <= tmo_d;
      loaded_cnt_q  <= loaded_cnt_d;
      addr_q        <= addr_d;
      load_q        <= load_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      prog_done_q   <= prog_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign opcode      = fields_q[0];
  assign sel         = fields_q[1];
  assign op1h        = fields_q[2];
  assign op1l        = fields_q[3];
  assign op2h        = fields_q[4];
  assign op2l        = fields_q[5];
  assign load        = load_q;
  assign addr        = addr_q;
  assign instr_valid = instr_valid_q;
  assign loaded_cnt  = loaded_cnt_q;
  assign busy        = busy_q;
  assign prog_done   = prog_done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_instr_load_sequencer.sv
// Directed bench for instr_load_sequencer (default parameters; FRAME_CHECKSUM_EN optional).
module tb_instr_load_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        start;
  logic        exec_done;
  logic [7:0]  opcode, sel, op1h, op1l, op2h, op2l;
  logic        load;
  logic [11:0] addr;
  logic        instr_valid;
  logic [11:0] loaded_cnt;
  logic        busy;
  logic        prog_done;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int load_pulses = 0;

  instr_load_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .start      (start),
    .exec_done  (exec_done),
    .opcode     (opcode),
    .sel        (sel),
    .op1h       (op1h),
    .op1l       (op1l),
    .op2h       (op2h),
    .op2l       (op2l),
    .load       (load),
    .addr       (addr),
    .instr_valid(instr_valid),
    .loaded_cnt (loaded_cnt),
    .busy       (busy),
    .prog_done  (prog_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (load) load_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    send_byte(b0); send_byte(b1); send_byte(b2);
    send_byte(b3); send_byte(b4); send_byte(b5);
`ifdef FRAME_CHECKSUM_EN
    send_byte(b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Pulse start or exec_done, then expect the 3-cycle fetch latency to instr_valid.
  task automatic step_to_valid(input logic is_start, input logic [11:0] exp_addr, input string tag);
    if (is_start) start = 1'b1; else exec_done = 1'b1;
    tick();
    start = 1'b0; exec_done = 1'b0;
    chk({tag, "_v1"}, 32'(instr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_v2"}, 32'(instr_valid), 32'd0);
    tick();
    chk({tag, "_v3"}, 32'(instr_valid), 32'd1);
    chk({tag, "_addr"}, 32'(addr), 32'(exp_addr));
  endtask

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; start = 1'b0; exec_done = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_cnt", 32'(loaded_cnt), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_flags", {28'd0, instr_valid, busy, prog_done, frame_err}, 32'd0);
    chk("rst_fields", {opcode, sel, op1h, op1l}, 32'd0);
    rst = 1'b1;
    tick();

    // Single frame: load one cycle after the last byte, fields in order
    send_frame(8'h01, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40);
    chk("f0_load", 32'(load), 32'd1);
    chk("f0_fields_a", {opcode, sel, op1h, op1l}, 32'h01021020);
    chk("f0_fields_b", {16'd0, op2h, op2l}, 32'h00003040);
    chk("f0_cnt", 32'(loaded_cnt), 32'd1);
    tick();
    chk("f0_load_off", 32'(load), 32'd0);
    chk("f0_fields_hold", {opcode, op2l}, 32'h0140);

    // Back-to-back frames (next byte arrives in the LOAD cycle), then overflow
    send_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6);
    send_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6);
    send_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6);
    chk("f3_fields", {opcode, sel, op2h, op2l}, 32'hC1C2C5C6);
    chk("f3_cnt", 32'(loaded_cnt), 32'd4);
    chk("f3_err", 32'(frame_err), 32'd0);
    send_frame(8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6);
    chk("full_load", 32'(load), 32'd0);
    chk("full_err", 32'(frame_err), 32'd1);
    chk("full_cnt", 32'(loaded_cnt), 32'd4);
    tick();
    chk("full_pulses", 32'(load_pulses), 32'd4);

    // RUN over three frames
    do_reset();
    tick();
    send_frame(8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    chk("run_cnt", 32'(loaded_cnt), 32'd3);
    step_to_valid(1'b1, 12'd0, "run0");
    tick(); tick();
    step_to_valid(1'b0, 12'd1, "run1");
    tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("run1_hold", {27'd0, prog_done, instr_valid, addr[2:0]}, {27'd0, 1'b0, 1'b0, 3'd2});
    tick();
    exec_done = 1'b1;           // arrives in WAIT: must be ignored
    tick();
    exec_done = 1'b0;
    chk("run2_v", 32'(instr_valid), 32'd1);
    chk("run2_addr", 32'(addr), 32'd2);
    tick(); tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("run_done", {29'd0, prog_done, busy, instr_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
    tick();
    chk("run_done_hold", {30'd0, prog_done, busy}, {30'd0, 1'b1, 1'b0});

    // Second RUN clears prog_done; reset while executing addr 1
    step_to_valid(1'b1, 12'd0, "rerun0");
    chk("rerun_pd", 32'(prog_done), 32'd0);
    tick(); tick();
    step_to_valid(1'b0, 12'd1, "rerun1");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_cnt_addr", {loaded_cnt, 4'd0, addr}, 32'd0);
    chk("abort_flags", {27'd0, load, instr_valid, busy, prog_done, frame_err}, 32'd0);
    chk("abort_fields", {opcode, sel, op2h, op2l}, 32'd0);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("start_ignored", {30'd0, busy, instr_valid}, 32'd0);

    // Timeout discards a partial frame
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    repeat (9999) tick();
    chk("tmo_early", 32'(frame_err), 32'd0);
    tick();
    chk("tmo_hit", 32'(frame_err), 32'd1);
    chk("tmo_fields_kept", {opcode, sel, op1h}, {8'd0, 8'hAA, 8'hBB, 8'hCC});
    send_frame(8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F);
    chk("tmo_next_load", 32'(load), 32'd1);
    chk("tmo_next_op", {opcode, op2l}, 32'h5A5F);
    chk("tmo_next_cnt", 32'(loaded_cnt), 32'd1);

`ifdef FRAME_CHECKSUM_EN
    do_reset();
    tick();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'h20); send_byte(8'h30); send_byte(8'h40); send_byte(8'h43);
    chk("cs_good_load", 32'(load), 32'd1);
    chk("cs_good_cnt", 32'(loaded_cnt), 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'h20); send_byte(8'h30); send_byte(8'h40); send_byte(8'h00);
    chk("cs_bad_load", 32'(load), 32'd0);
    chk("cs_bad_err", 32'(frame_err), 32'd1);
    chk("cs_bad_cnt", 32'(loaded_cnt), 32'd1);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
